div_seq_8bit: RTL and testbench

DIV_SEQ_8BIT -- requirements
Module: div_seq_8bit

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 25 ++
 rtl/div_seq_8bit.sv | 103 ++++++++++
 tb/tb_div_seq_8bit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared width and FSM state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;

    // One extra bit above the trial value holds the borrow of the subtraction.
    assign trial   = {rem, dvd_msb};
    assign diff    = {1'b0, trial} - {2'b00, divisor};
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_nxt = q_bit ? WIDTH'(diff[WIDTH:0]) : WIDTH'(trial);

endmodule

// File: rtl/div_seq_8bit.sv
// Sequential restoring divider: quotient/remainder of dividend/divisor, divide-by-zero flagged.
// Latency: WIDTH+1 cycles from start to done (1 cycle when divisor is 0).
// Backpressure: start is ignored while busy; results hold until the next done.
module div_seq_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .dvd_msb (dvd_reg[WIDTH-1]),
        .divisor (dvs_reg),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            rem       <= '0;
            q_reg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_reg <= dividend;
                        dvs_reg <= divisor;
                        rem     <= '0;
                        q_reg   <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem     <= rem_nxt;
                    q_reg   <= {q_reg[WIDTH-2:0], q_bit};
                    dvd_reg <= dvd_reg << 1;
                    cnt     <= cnt + 1'b1;
                    // Last iteration publishes the results straight from the step logic.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= {q_reg[WIDTH-2:0], q_bit};
                        remainder <= rem_nxt;
                        div_zero  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_8bit.sv
// Directed and random checks of the sequential divider against hand-computed and modelled results.
module tb_div_seq_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int checks;
    int failures;

    div_seq_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Counts cycles until done is seen; lat0 is the count already elapsed.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 99;
    endtask

    // Called on a negedge; returns on the negedge where done is high.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        logic [7:0] q_seen;
        logic [7:0] r_seen;
        logic [7:0] ra;
        logic [7:0] rb;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);

        // Start on the very first edge after reset release.
        rst = 1'b0;
        run_div(8'd100, 8'd7, lat);
        chk("100_7_lat", lat, 9);
        chk("100_7_q", quotient, 14);
        chk("100_7_r", remainder, 2);
        chk("100_7_dz", div_zero, 0);
        @(negedge clk);
        chk("done_pulse_1cyc", done, 0);
        chk("busy_low_after", busy, 0);
        repeat (3) @(negedge clk);
        chk("hold_q", quotient, 14);
        chk("hold_r", remainder, 2);

        run_div(8'd255, 8'd1, lat);
        chk("255_1_q", quotient, 255);
        chk("255_1_r", remainder, 0);
        @(negedge clk);
        run_div(8'd5, 8'd9, lat);
        chk("5_9_q", quotient, 0);
        chk("5_9_r", remainder, 5);
        @(negedge clk);
        run_div(8'd255, 8'd255, lat);
        chk("255_255_q", quotient, 1);
        chk("255_255_r", remainder, 0);
        @(negedge clk);

        run_div(8'd42, 8'd0, lat);
        chk("42_0_lat", lat, 1);
        chk("42_0_q", quotient, 8'hFF);
        chk("42_0_r", remainder, 42);
        chk("42_0_dz", div_zero, 1);
        @(negedge clk);
        chk("dz_done_pulse", done, 0);

        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        chk("dz_hold_midrun", div_zero, 1);
        chk("q_hold_midrun", quotient, 8'hFF);
        wait_done(1, lat);
        chk("10_3_lat", lat, 9);
        chk("10_3_q", quotient, 3);
        chk("10_3_r", remainder, 1);
        chk("10_3_dz", div_zero, 0);
        @(negedge clk);

        // A second start while busy must not disturb the running division.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd13;
        busy_cnt = 0;
        done_cnt = 0;
        q_seen   = '0;
        r_seen   = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 4);
            if (c == 4) begin
                dividend = 8'd9;
                divisor  = 8'd2;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                q_seen = quotient;
                r_seen = remainder;
            end
        end
        chk("ign_busy_cycles", busy_cnt, 9);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_q", q_seen, 15);
        chk("ign_r", r_seen, 5);

        // Abort mid-RUN with an asynchronous reset.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        run_div(8'd77, 8'd6, lat);
        chk("77_6_lat", lat, 9);
        chk("77_6_q", quotient, 12);
        chk("77_6_r", remainder, 5);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i < 4) rb = 8'(i);
            run_div(ra, rb, lat);
            if (rb == 0) begin
                chk("rnd_lat_z", lat, 1);
                chk("rnd_q_z", quotient, 8'hFF);
                chk("rnd_r_z", remainder, ra);
                chk("rnd_dz_z", div_zero, 1);
            end else begin
                chk("rnd_lat", lat, 9);
                chk("rnd_ident", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
                chk("rnd_r_lt_d", 32'(remainder < rb), 1);
                chk("rnd_q", quotient, ra / rb);
                chk("rnd_dz", div_zero, 0);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
